// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that drives the select of a downstream 4:1 mux.
// Optional forced release after HOLD_CYCLES is enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_sel_arbiter #(
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] winner, idx;
  logic       found;
  logic       forceRel;
  logic       normalRel;

  // First requesting channel found searching upward from ptr, wrapping 3->0.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + i[1:0];
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign normalRel = done || !req[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = winner;
          grant_d = 4'(1) << winner;
        end
      end
      GRANT: begin
        if (normalRel || forceRel) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          ptr_d   = sel_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      grant_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  // Counter is zero on the first grant cycle; done or a dropped request wins over the timeout.
  assign forceRel  = (state_q == GRANT) && (cnt_q == HoldLast);
  assign cnt_d     = (state_q == GRANT) ? cnt_q + 8'd1 : 8'd0;
  assign timeout_d = forceRel && !normalRel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign forceRel = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign sel   = sel_q;
  assign grant = grant_q;
  assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed vector bench for mux_sel_arbiter; covers both MUX_ARB_TIMEOUT_EN builds.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [1:0] expSel;
    logic [3:0] expGrant;
    logic       expBusy;
  } vec_t;

  vec_t vecs[24];

  mux_sel_arbiter #(.HOLD_CYCLES(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] r, input logic d);
    @(negedge clk);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] eSel,
                             input logic [3:0] eGrant, input logic eBusy,
                             input logic eTo);
    vectors++;
    if (sel !== eSel || grant !== eGrant || busy !== eBusy || timeout !== eTo) begin
      miscompares++;
      $display("[TB] FAIL %s: got sel=%b grant=%b busy=%b timeout=%b, expected sel=%b grant=%b busy=%b timeout=%b",
               name, sel, grant, busy, timeout, eSel, eGrant, eBusy, eTo);
    end
  endtask

  initial begin
    // Sequence starts from reset: ptr=0, sel=0.
    vecs[0]  = '{4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0};
    vecs[1]  = '{4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1};
    vecs[2]  = '{4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0};
    vecs[3]  = '{4'b1111, 1'b0, 2'd1, 4'b0010, 1'b1};
    vecs[4]  = '{4'b1111, 1'b1, 2'd1, 4'b0000, 1'b0};
    vecs[5]  = '{4'b1111, 1'b0, 2'd2, 4'b0100, 1'b1};
    vecs[6]  = '{4'b1111, 1'b1, 2'd2, 4'b0000, 1'b0};
    vecs[7]  = '{4'b1111, 1'b0, 2'd3, 4'b1000, 1'b1};
    vecs[8]  = '{4'b1111, 1'b1, 2'd3, 4'b0000, 1'b0};
    vecs[9]  = '{4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1};
    vecs[10] = '{4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0};
    vecs[11] = '{4'b1000, 1'b0, 2'd3, 4'b1000, 1'b1};
    vecs[12] = '{4'b1000, 1'b1, 2'd3, 4'b0000, 1'b0};
    vecs[13] = '{4'b1001, 1'b0, 2'd0, 4'b0001, 1'b1};
    vecs[14] = '{4'b1001, 1'b1, 2'd0, 4'b0000, 1'b0};
    vecs[15] = '{4'b1010, 1'b0, 2'd1, 4'b0010, 1'b1};
    vecs[16] = '{4'b1110, 1'b0, 2'd1, 4'b0010, 1'b1};
    vecs[17] = '{4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1};
    vecs[18] = '{4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0};
    vecs[19] = '{4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1};
    vecs[20] = '{4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0};
    vecs[21] = '{4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1};
    vecs[22] = '{4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0};
    vecs[23] = '{4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0};

    rst_n = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    #1 rst_n = 1'b0;
    #2 checkOutput("asyncResetNoEdge", 2'd0, 4'b0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].req, vecs[i].done);
      checkOutput($sformatf("vec%0d", i), vecs[i].expSel, vecs[i].expGrant,
                  vecs[i].expBusy, 1'b0);
    end

    // ptr=1 here; channel 1 is held with done low.
    applyStimulus(4'b0010, 1'b0);
    checkOutput("holdGrantEntry", 2'd1, 4'b0010, 1'b1, 1'b0);
`ifdef MUX_ARB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      applyStimulus(4'b0010, 1'b0);
      checkOutput($sformatf("holdCycle%0d", i), 2'd1, 4'b0010, 1'b1, 1'b0);
    end
    applyStimulus(4'b0010, 1'b0);
    checkOutput("timeoutRelease", 2'd1, 4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("timeoutRegrant", 2'd1, 4'b0010, 1'b1, 1'b0);
`else
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(4'b0010, 1'b0);
      checkOutput($sformatf("holdCycle%0d", i), 2'd1, 4'b0010, 1'b1, 1'b0);
    end
`endif
    applyStimulus(4'b0010, 1'b1);
    checkOutput("holdDoneRelease", 2'd1, 4'b0000, 1'b0, 1'b0);

    // ptr=2; reset lands in the middle of channel 2's grant.
    applyStimulus(4'b0100, 1'b0);
    checkOutput("preResetGrant", 2'd2, 4'b0100, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkOutput("midGrantReset", 2'd0, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1 checkOutput("resetHeldOverEdge", 2'd0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 checkOutput("firstEdgeAfterReset", 2'd2, 4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("postResetRelease", 2'd2, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("postResetPtrAdvance", 2'd3, 4'b1000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
- REQ-001 Parameter HOLD_CYCLES, default 8, maximum cycles a grant is held when timeout is compiled in; legal range 1..255.
- REQ-002 Port clk, input, 1, rising-edge clock for all state.
- REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
- REQ-004 Port req, input, 4, per-channel request; bit i requests mux input i (i=0..3 maps to a,b,c,d).
- REQ-005 Port done, input, 1, current owner releases its grant.
- REQ-006 Port sel, output, 2, registered select driven to the downstream 4:1 mux sel port.
- REQ-007 Port grant, output, 4, registered one-hot grant; all-zero when no owner.
- REQ-008 Port busy, output, 1, high while a grant is active.
- REQ-009 Port timeout, output, 1, one-cycle pulse on forced release.

Function
- REQ-010 FSM states SHALL be IDLE and GRANT.
- REQ-011 In IDLE with req != 0 at a rising edge, the block SHALL enter GRANT and register the winner into sel, grant and busy, so that they are valid one cycle after the sampling edge.
- REQ-012 The winner SHALL be the first set req bit found searching upward from pointer ptr, wrapping 3->0.
- REQ-013 On every release, ptr SHALL become (sel+1) mod 4; ptr resets to 0.
- REQ-014 In GRANT, the block SHALL release (go to IDLE, grant=0000, busy=0) at the edge where done=1 or req[sel]=0.
- REQ-015 After every release the block SHALL spend at least one cycle in IDLE before the next grant, giving the mux a one-cycle gap.
- REQ-016 sel SHALL hold the last granted value while in IDLE; it changes only when a new grant is issued.
- REQ-017 done SHALL be ignored in IDLE.
- REQ-018 Changes on req bits other than req[sel] SHALL be ignored during GRANT.
- REQ-019 grant SHALL always equal one-hot(sel) while busy=1, and 0000 while busy=0.
- REQ-020 When done=1 coincides with a forced-release condition, the block SHALL perform a single release with timeout=0.

Reset
- REQ-021 While rst_n=0, outputs SHALL be sel=00, grant=0000, busy=0 and timeout=0, with state IDLE, ptr=0 and hold counter=0, independent of clk.
- REQ-022 Reset asserted mid-GRANT SHALL clear all outputs immediately and leave no pending grant after deassertion.
- REQ-023 The first edge after rst_n rises SHALL be treated as a normal IDLE sampling edge.

Configuration
- REQ-024 Macro MUX_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on grant entry and increment each cycle in GRANT. When it reaches HOLD_CYCLES-1 without a release, the block SHALL force a release and pulse timeout=1 for exactly the release cycle.
- REQ-025 Macro MUX_ARB_TIMEOUT_EN undefined: the counter SHALL be absent, timeout SHALL be tied to 0, and a grant SHALL persist until done=1 or req[sel]=0.

Verification
- REQ-026 Reset: assert rst_n=0 asynchronously -> sel=00, grant=0000, busy=0, timeout=0 with no clock edge.
- REQ-027 Single request: req=0100 -> next cycle grant=0100, sel=10, busy=1. Then done=1 -> next cycle grant=0000, busy=0, sel stays 10.
- REQ-028 Round-robin: req=1111 held, done pulsed one cycle after each grant -> grants 0001, 0010, 0100, 1000, 0001, each separated by one IDLE cycle.
- REQ-029 Wrap and skip: after channel 3 released, req=1001 -> grant=0001. After channel 0 released, req=1010 -> grant=0010.
- REQ-030 Timeout, MUX_ARB_TIMEOUT_EN defined, HOLD_CYCLES=8: req=0010 held, done=0 -> busy high for 8 cycles, release, timeout pulses once, regrant after 1 IDLE cycle. With the macro undefined: grant=0010 is held for at least 20 cycles and timeout stays 0.
- REQ-031 Reset mid-operation: rst_n=0 during GRANT of channel 2 -> outputs clear at once. After release with req=0100 held, the first grant is re-issued for channel 2 (ptr=0, channels 0 and 1 idle).
